// File: rtl/label_ram_writer_if.sv
// label_ram_writer_if: pixel stream in, label RAM write port and published box out
interface label_ram_writer_if;
  logic        vsync;
  logic        pix_valid;
  logic [2:0]  pix_label;
  logic        we;
  logic [16:0] wAddr;
  logic [2:0]  wData;
  logic [9:0]  x_min, y_min, x_max, y_max;
  logic        box_valid;
  logic        frame_done;
  logic        frame_err;
  modport master (
    output vsync, pix_valid, pix_label,
    input  we, wAddr, wData, x_min, y_min, x_max, y_max, box_valid, frame_done, frame_err
  );
  modport slave (
    input  vsync, pix_valid, pix_label,
    output we, wAddr, wData, x_min, y_min, x_max, y_max, box_valid, frame_done, frame_err
  );
endinterface

// File: rtl/label_ram_writer.sv
// label_ram_writer: writes one frame of pixel labels to RAM and tracks a label's bounding box
module label_ram_writer #(
  parameter int          H_ACT     = 320,
  parameter int          V_ACT     = 240,
  parameter logic [2:0]  BOX_LABEL = 3'b011
) (
  input logic clk,
  input logic reset,
  label_ram_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam logic [16:0] LAST = 17'(H_ACT * V_ACT - 1);
  localparam logic [9:0]  XL   = 10'(H_ACT - 1);
  state_t      state, nxt;
  logic        vs_q, pend, vs_rise, acc, last, hit_px, hit, nhit;
  logic [9:0]  x, y, xmin, ymin, xmax, ymax, nxmin, nymin, nxmax, nymax;
  logic [16:0] addr;
  assign vs_rise = bus.vsync & ~vs_q;
  assign acc     = (state == CAPTURE) && bus.pix_valid && !vs_rise;
  assign last    = addr == LAST;
  assign hit_px  = acc && (bus.pix_label == BOX_LABEL);
  assign nxmin   = hit_px && x < xmin ? x : xmin;
  assign nymin   = hit_px && y < ymin ? y : ymin;
  assign nxmax   = hit_px && x > xmax ? x : xmax;
  assign nymax   = hit_px && y > ymax ? y : ymax;
  assign nhit    = hit | hit_px;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = vs_rise || pend ? ARMED : IDLE;
      ARMED:   nxt = bus.vsync ? ARMED : CAPTURE;
      CAPTURE: nxt = vs_rise ? ARMED : (acc && last ? DONE : CAPTURE);
      DONE:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  // published box is loaded on the last pixel so it is visible alongside frame_done in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q           <= 1'b1;
      pend           <= 1'b0;
      bus.we         <= 1'b0;
      bus.wAddr      <= '0;
      bus.wData      <= '0;
      bus.x_min      <= '0;
      bus.y_min      <= '0;
      bus.x_max      <= '0;
      bus.y_max      <= '0;
      bus.box_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      x              <= '0;
      y              <= '0;
      addr           <= '0;
      xmin           <= '1;
      ymin           <= '1;
      xmax           <= '0;
      ymax           <= '0;
      hit            <= 1'b0;
    end else begin
      vs_q           <= bus.vsync;
      pend           <= (state == DONE) && vs_rise;
      bus.we         <= acc;
      bus.frame_done <= acc && last;
      bus.frame_err  <= (state == CAPTURE) && vs_rise;
      if (state == ARMED && !bus.vsync) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
        xmin <= '1;
        ymin <= '1;
        xmax <= '0;
        ymax <= '0;
        hit  <= 1'b0;
      end
      if (acc) begin
        bus.wAddr <= addr;
        bus.wData <= bus.pix_label;
        addr      <= addr + 17'd1;
        x         <= x == XL ? 10'd0 : x + 10'd1;
        y         <= x == XL ? y + 10'd1 : y;
        xmin      <= nxmin;
        ymin      <= nymin;
        xmax      <= nxmax;
        ymax      <= nymax;
        hit       <= nhit;
      end
      if (acc && last) begin
        bus.x_min     <= nhit ? nxmin : 10'd0;
        bus.y_min     <= nhit ? nymin : 10'd0;
        bus.x_max     <= nhit ? nxmax : 10'd0;
        bus.y_max     <= nhit ? nymax : 10'd0;
        bus.box_valid <= nhit;
      end
    end
  end
endmodule

// File: tb/tb_label_ram_writer.sv
// tb_label_ram_writer: random-label frames checked against a frame-level write/box model
module tb_label_ram_writer;
  localparam int H = 16, V = 12, N = H * V;
  typedef struct {int c; int a; int d;} wr_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  label_ram_writer_if bus();
  label_ram_writer #(.H_ACT(H), .V_ACT(V)) dut (.clk(clk), .reset(reset), .bus(bus));
  int cyc = 0, n_chk = 0, n_err = 0, done_cnt = 0, err_cnt = 0;
  logic [2:0] lab [N];
  wr_t expq[$];
  wr_t e_m;
  logic [9:0] sx0, sy0, sx1, sy1;
  logic sv;
  int ex0, ey0, ex1, ey1, ev, px0, py0, px1, py1, pv;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      if (expq.size() == 0) check("unexpected_we", 1, 0);
      else begin
        e_m = expq.pop_front();
        check("wr_cycle", cyc, e_m.c);
        check("wAddr", bus.wAddr, e_m.a);
        check("wData", bus.wData, e_m.d);
      end
    end
    if (bus.frame_done === 1'b1) begin
      done_cnt++;
      {sx0, sy0, sx1, sy1, sv} = {bus.x_min, bus.y_min, bus.x_max, bus.y_max, bus.box_valid};
    end
    if (bus.frame_err === 1'b1) err_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill_rand(input bit allow_box);
    for (int k = 0; k < N; k++) begin
      lab[k] = 3'($urandom_range(0, 4));
      if (!allow_box && lab[k] == 3'd3) lab[k] = 3'd4;
    end
  endtask
  task automatic calc_box();
    ex0 = 1023; ey0 = 1023; ex1 = 0; ey1 = 0; ev = 0;
    for (int k = 0; k < N; k++)
      if (lab[k] == 3'd3) begin
        ev = 1;
        if (k % H < ex0) ex0 = k % H;
        if (k / H < ey0) ey0 = k / H;
        if (k % H > ex1) ex1 = k % H;
        if (k / H > ey1) ey1 = k / H;
      end
    if (ev == 0) begin ex0 = 0; ey0 = 0; end
  endtask
  task automatic start_frame();
    bus.vsync = 1'b0; tick();
    bus.vsync = 1'b1; tick(); tick();
    bus.vsync = 1'b0; tick();
  endtask
  task automatic run_pixels(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat (2) begin
        bus.pix_valid = 1'b0;
        bus.pix_label = 3'($urandom_range(0, 7));
        tick();
      end
      bus.pix_valid = 1'b1;
      bus.pix_label = lab[k];
      expq.push_back('{cyc + 1, k, int'(lab[k])});
      tick();
    end
    bus.pix_valid = 1'b0;
  endtask
  task automatic check_frame(input string tag);
    calc_box();
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_x_min"}, sx0, ex0);
    check({tag, "_y_min"}, sy0, ey0);
    check({tag, "_x_max"}, sx1, ex1);
    check({tag, "_y_max"}, sy1, ey1);
    check({tag, "_box_valid"}, sv, ev);
    check({tag, "_pending_writes"}, expq.size(), 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    {px0, py0, px1, py1, pv} = {ex0, ey0, ex1, ey1, ev};
    done_cnt = 0;
    err_cnt = 0;
  endtask
  task automatic end_frame(input string tag);
    repeat (3) tick();
    check_frame(tag);
  endtask
  initial begin
    bus.vsync = 1'b1; bus.pix_valid = 1'b0; bus.pix_label = 3'd0;
    repeat (3) tick();
    check("rst_we", bus.we, 0);
    check("rst_wAddr", bus.wAddr, 0);
    check("rst_wData", bus.wData, 0);
    check("rst_box", {bus.x_min, bus.y_min, bus.x_max, bus.y_max}, 0);
    check("rst_box_valid", bus.box_valid, 0);
    check("rst_done_err", {bus.frame_done, bus.frame_err}, 0);
    reset = 1'b0;
    // vsync already high at release is not an edge: pixels must be ignored
    for (int k = 0; k < 10; k++) begin
      if (k == 5) bus.vsync = 1'b0;
      bus.pix_valid = 1'b1;
      bus.pix_label = 3'($urandom_range(0, 4));
      tick();
    end
    bus.pix_valid = 1'b0;
    tick();
    check("idle_no_done", done_cnt, 0);
    for (int k = 0; k < N; k++) lab[k] = 3'd2;
    start_frame();
    run_pixels(N, 0);
    end_frame("bg");
    fill_rand(0);
    lab[2 * H + 3] = 3'd3;
    lab[9 * H + 12] = 3'd3;
    start_frame();
    run_pixels(N, 0);
    // vsync rises during DONE and must still start the next frame
    bus.vsync = 1'b1; tick(); tick();
    bus.vsync = 1'b0; tick();
    check_frame("two_pts");
    for (int k = 0; k < N; k++) lab[k] = 3'd2;
    lab[N - 1] = 3'd3;
    run_pixels(N, 0);
    end_frame("last_px");
    fill_rand(1);
    start_frame();
    run_pixels(N, 1);
    end_frame("gaps");
    fill_rand(1);
    start_frame();
    run_pixels(100, 0);
    bus.pix_valid = 1'b1;
    bus.pix_label = 3'd3;
    bus.vsync = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    bus.vsync = 1'b0;
    tick();
    check("abort_err_cnt", err_cnt, 1);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_pending", expq.size(), 0);
    check("abort_box_kept", {bus.x_min, bus.y_min, bus.x_max, bus.y_max}, {10'(px0), 10'(py0), 10'(px1), 10'(py1)});
    check("abort_valid_kept", bus.box_valid, pv);
    err_cnt = 0;
    fill_rand(1);
    run_pixels(N, 0);
    end_frame("after_abort");
    fill_rand(1);
    start_frame();
    run_pixels(H + 5, 0);
    reset = 1'b1;
    bus.pix_valid = 1'b1;
    tick();
    check("rst_mid_we", bus.we, 0);
    tick();
    reset = 1'b0;
    check("rst_mid_wAddr", bus.wAddr, 0);
    check("rst_mid_box_valid", bus.box_valid, 0);
    for (int k = 0; k < 8; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_label = 3'($urandom_range(0, 4));
      tick();
    end
    bus.pix_valid = 1'b0;
    tick();
    check("rst_mid_pending", expq.size(), 0);
    check("rst_mid_done", done_cnt, 0);
    fill_rand(1);
    start_frame();
    run_pixels(N, 0);
    end_frame("after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/label_ram_writer.md
LABEL_RAM_WRITER -- requirements
Module: label_ram_writer

Interface
REQ-001 Parameter H_ACT, default 320: active pixels per line.
REQ-002 Parameter V_ACT, default 240: active lines per frame.
REQ-003 Parameter BOX_LABEL, default 3'b011 (CAR): the label tracked by the bounding box.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 vsync  input  1  frame sync level; a rising edge marks a frame boundary.
REQ-007 pix_valid  input  1  pix_label is valid this cycle (at most one pixel per cycle, raster order).
REQ-008 pix_label  input  3  class label: 000 ROAD, 001 WALKROAD, 010 BACKGROUND, 011 CAR, 100 HUMAN.
REQ-009 we  output  1  label RAM write enable.
REQ-010 wAddr  output  17  label RAM write address.
REQ-011 wData  output  3  label RAM write data.
REQ-012 x_min, y_min, x_max, y_max  output  10 each  published BOX_LABEL bounding box.
REQ-013 box_valid  output  1  the published box contains at least one BOX_LABEL pixel.
REQ-014 frame_done  output  1  one-cycle pulse when a complete frame is published.
REQ-015 frame_err  output  1  one-cycle pulse when a short frame is aborted.

Function
REQ-016 The FSM SHALL have four states: IDLE, ARMED, CAPTURE and DONE.
REQ-017 The FSM SHALL leave IDLE for ARMED on a vsync rising edge (registered vsync low, current vsync high).
REQ-018 The FSM SHALL go from ARMED to CAPTURE when vsync is low, clearing the x/y counters, the address counter and the working box (min = 10'h3FF, max = 0, hit = 0).
REQ-019 In CAPTURE, each pix_valid SHALL be written exactly one cycle later: we = 1, wAddr = y*H_ACT + x, wData = pix_label.
REQ-020 we SHALL be 0 in every cycle that does not carry an accepted pixel.
REQ-021 x SHALL advance 0..H_ACT-1 per accepted pixel; at H_ACT-1 it SHALL wrap to 0 and y SHALL increment.
REQ-022 wAddr SHALL be generated by an incrementing counter (no multiplier) and SHALL never exceed H_ACT*V_ACT-1 (76799).
REQ-023 An accepted pixel with label equal to BOX_LABEL SHALL update the working box: min = min(min, coordinate) and max = max(max, coordinate) per axis, and set hit.
REQ-024 Acceptance of pixel H_ACT*V_ACT-1 (x = 319, y = 239) SHALL write that pixel and move the FSM to DONE.
REQ-025 In DONE, for one cycle: if hit, the four box outputs SHALL take the working box and box_valid = 1; otherwise the box outputs SHALL be 0 and box_valid = 0.
REQ-026 DONE SHALL assert frame_done = 1 for that same cycle and then return to IDLE.
REQ-027 The box outputs and box_valid SHALL hold their values between DONE cycles.
REQ-028 A vsync rising edge in CAPTURE before the frame completes SHALL discard any pixel in that cycle, pulse frame_err one cycle later, leave the published box unchanged, and go to ARMED.
REQ-029 pix_valid in IDLE, ARMED or DONE SHALL be ignored (no write, no box update).
REQ-030 A vsync rising edge in DONE SHALL be captured so that IDLE moves directly to ARMED.

Reset
REQ-031 While reset = 1, the FSM SHALL go to IDLE and we, wAddr, wData, x_min, y_min, x_max, y_max, box_valid, frame_done, frame_err and the counters SHALL be 0 on the next edge.
REQ-032 A reset during CAPTURE SHALL abort the frame with no further writes, and a new vsync rising edge SHALL be required before capture resumes.
REQ-033 The registered vsync SHALL reset to 1, so that a vsync already high at reset release is not taken as an edge.

Verification
REQ-034 Full frame of all 010 -> 76800 writes, addresses 0..76799 in order, each one cycle after its pixel; frame_done pulses once; box_valid = 0; box outputs = 0.
REQ-035 Full frame with 011 only at (10,20) and (200,150) -> x_min = 10, y_min = 20, x_max = 200, y_max = 150, box_valid = 1 in the frame_done cycle.
REQ-036 Single 011 pixel at (319,239), the last pixel -> written at address 76799; box = (319,239,319,239); box_valid = 1.
REQ-037 vsync rises after 1000 pixels, with pix_valid high in the same cycle -> exactly 1000 writes; frame_err pulses once; previous box retained; next frame starts at wAddr 0.
REQ-038 Reset asserted mid-line at x = 57 -> we = 0 from the next cycle; pixels before the next vsync edge are ignored; the next frame starts at wAddr 0.
REQ-039 pix_valid with gaps (1 of 3 cycles) -> same addresses and data as the dense frame; no write in gap cycles.
